// File: rtl/cache_ctrl.sv
// Sequencing controller for a 4-set 2-way write-through, no-write-allocate data cache.
// Optional CACHE_STATS_EN adds saturating read hit/miss counters (stat_hits, stat_misses).
module cache_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,
    input  logic                  c_hit,
    input  logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_fill_we,
    output logic [DATA_WIDTH-1:0] c_fill_addr,
    output logic [DATA_WIDTH-1:0] c_fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MEM_RD = 3'd1;
    localparam logic [2:0] S_MEM_WR = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_reg;
    logic [DATA_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  we_reg;
    logic                  hit_reg;
    logic                  err_reg;
    logic [CW-1:0]         cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            data_reg  <= '0;
            we_reg    <= 1'b0;
            hit_reg   <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        we_reg    <= cpu_we;
                        hit_reg   <= c_hit;
                        err_reg   <= 1'b0;
                        cnt_reg   <= '0;
                        data_reg  <= '0;
                        if (cpu_we) begin
                            state_reg <= S_MEM_WR;
                        end else if (c_hit) begin
                            data_reg  <= c_rdata;
                            state_reg <= S_RESP;
                        end else begin
                            state_reg <= S_MEM_RD;
                        end
                    end
                end
                S_MEM_RD, S_MEM_WR: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (mem_ack) begin
                        if (state_reg == S_MEM_RD) begin
                            data_reg  <= mem_rdata;
                            state_reg <= S_FILL;
                        end else begin
                            state_reg <= hit_reg ? S_FILL : S_RESP;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_FILL:  state_reg <= S_RESP;
                S_RESP:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // All outputs decode from registered state, so none depend combinationally on inputs.
    assign cpu_ready   = (state_reg == S_RESP);
    assign cpu_err     = cpu_ready && err_reg;
    assign cpu_rdata   = (cpu_ready && !we_reg && !err_reg) ? data_reg : '0;
    assign c_fill_we   = (state_reg == S_FILL);
    assign c_fill_addr = c_fill_we ? addr_reg : '0;
    assign c_fill_data = c_fill_we ? (we_reg ? wdata_reg : data_reg) : '0;
    assign mem_req     = (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);
    assign mem_we      = (state_reg == S_MEM_WR);
    assign mem_addr    = mem_req ? addr_reg : '0;
    assign mem_wdata   = mem_we ? wdata_reg : '0;

`ifdef CACHE_STATS_EN
    logic [31:0] hits_reg;
    logic [31:0] misses_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_reg   <= '0;
            misses_reg <= '0;
        end else if (state_reg == S_IDLE && cpu_req && !cpu_we) begin
            if (c_hit && hits_reg != 32'hFFFF_FFFF)
                hits_reg <= hits_reg + 32'd1;
            else if (!c_hit && misses_reg != 32'hFFFF_FFFF)
                misses_reg <= misses_reg + 32'd1;
        end
    end

    assign stat_hits   = hits_reg;
    assign stat_misses = misses_reg;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: responses and cache fills are queued as expected
// when a request is issued and checked by a monitor as the controller produces them.
module tb_cache_ctrl;
    localparam int DW = 32;
    localparam int TC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_err;
    logic          c_hit = 1'b0;
    logic [DW-1:0] c_rdata = '0;
    logic          c_fill_we;
    logic [DW-1:0] c_fill_addr;
    logic [DW-1:0] c_fill_data;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;
`endif

    cache_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .c_hit(c_hit), .c_rdata(c_rdata),
        .c_fill_we(c_fill_we), .c_fill_addr(c_fill_addr), .c_fill_data(c_fill_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] rdata; logic err; } resp_t;
    typedef struct { logic [DW-1:0] addr; logic [DW-1:0] data; } fill_t;

    resp_t resp_q[$];
    fill_t fill_q[$];
    resp_t mon_r;
    fill_t mon_f;

    int checks = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ready) begin
                checks++;
                if (resp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: got rdata=%h err=%b, expected no response", cpu_rdata, cpu_err);
                end else begin
                    mon_r = resp_q.pop_front();
                    if (cpu_rdata !== mon_r.rdata || cpu_err !== mon_r.err) begin
                        failures++;
                        $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                                 cpu_rdata, cpu_err, mon_r.rdata, mon_r.err);
                    end
                end
            end
            if (c_fill_we) begin
                checks++;
                if (fill_q.size() == 0) begin
                    failures++;
                    $display("FAIL fill_unexpected: got addr=%h data=%h, expected no fill", c_fill_addr, c_fill_data);
                end else begin
                    mon_f = fill_q.pop_front();
                    if (c_fill_addr !== mon_f.addr || c_fill_data !== mon_f.data) begin
                        failures++;
                        $display("FAIL fill_data: got addr=%h data=%h, expected addr=%h data=%h",
                                 c_fill_addr, c_fill_data, mon_f.addr, mon_f.data);
                    end
                end
            end
        end
    end

    // Issue one request, answer the memory side after ack_lat cycles of mem_req (never if <= 0).
    task automatic run_txn(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic hit, input logic [DW-1:0] crdata, input int ack_lat,
                           input logic [DW-1:0] mrdata, output int lat, output int req_cycles);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        c_hit = hit; c_rdata = crdata;
        lat = 0;
        req_cycles = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (cpu_ready) break;
            if (mem_req) begin
                req_cycles++;
                checks++;
                if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) begin
                    failures++;
                    $display("FAIL mem_bus: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, we, addr, wdata);
                end
                if (req_cycles == ack_lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = mrdata;
                end
            end
        end
        checks++;
        if (cpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL txn_no_ready: got cpu_ready=%b after %0d cycles, expected 1", cpu_ready, lat);
        end
        cpu_req = 1'b0; c_hit = 1'b0; c_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (resp_q.size() != 0 || fill_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_pending: got resp=%0d fill=%0d outstanding, expected 0 0",
                     resp_q.size(), fill_q.size());
            resp_q.delete();
            fill_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_ready, cpu_err, c_fill_we, mem_req, mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, expected 00000", {cpu_ready, cpu_err, c_fill_we, mem_req, mem_we});
        end
        checks++;
        if ((cpu_rdata | c_fill_addr | c_fill_data | mem_addr | mem_wdata) !== '0) begin
            failures++;
            $display("FAIL reset_data: got or-of-buses=%h, expected 0",
                     cpu_rdata | c_fill_addr | c_fill_data | mem_addr | mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_hit();
        int lat, rc;
        resp_q.push_back('{32'hDEADBEEF, 1'b0});
        run_txn(1'b0, 32'h40, '0, 1'b1, 32'hDEADBEEF, 0, '0, lat, rc);
        checks++;
        if (lat != 1 || rc != 0) begin
            failures++;
            $display("FAIL read_hit_timing: got lat=%0d memreq=%0d, expected lat=1 memreq=0", lat, rc);
        end
        resp_q.push_back('{32'h0BADF00D, 1'b0});
        run_txn(1'b0, 32'h44, '0, 1'b1, 32'h0BADF00D, 0, '0, lat, rc);
        checks++;
        if (lat != 1 || rc != 0) begin
            failures++;
            $display("FAIL read_hit2_timing: got lat=%0d memreq=%0d, expected lat=1 memreq=0", lat, rc);
        end
    endtask

    task automatic test_read_miss();
        int lat, rc;
        fill_q.push_back('{32'h40, 32'h12345678});
        resp_q.push_back('{32'h12345678, 1'b0});
        run_txn(1'b0, 32'h40, '0, 1'b0, 32'hFFFFFFFF, 3, 32'h12345678, lat, rc);
        checks++;
        if (lat != 5 || rc != 3) begin
            failures++;
            $display("FAIL read_miss_timing: got lat=%0d memreq=%0d, expected lat=5 memreq=3", lat, rc);
        end
        fill_q.push_back('{32'h1C, 32'hCAFEF00D});
        resp_q.push_back('{32'hCAFEF00D, 1'b0});
        run_txn(1'b0, 32'h1C, '0, 1'b0, '0, 1, 32'hCAFEF00D, lat, rc);
        checks++;
        if (lat != 3 || rc != 1) begin
            failures++;
            $display("FAIL read_miss_n1_timing: got lat=%0d memreq=%0d, expected lat=3 memreq=1", lat, rc);
        end
    endtask

    task automatic test_write();
        int lat, rc;
        fill_q.push_back('{32'h80, 32'hA5A5A5A5});
        resp_q.push_back('{32'h0, 1'b0});
        run_txn(1'b1, 32'h80, 32'hA5A5A5A5, 1'b1, 32'hFFFFFFFF, 2, 32'h77777777, lat, rc);
        checks++;
        if (lat != 4 || rc != 2) begin
            failures++;
            $display("FAIL write_hit_timing: got lat=%0d memreq=%0d, expected lat=4 memreq=2", lat, rc);
        end
        resp_q.push_back('{32'h0, 1'b0});
        run_txn(1'b1, 32'hC4, 32'h5A5A0001, 1'b0, 32'hFFFFFFFF, 2, 32'h77777777, lat, rc);
        checks++;
        if (lat != 3 || rc != 2) begin
            failures++;
            $display("FAIL write_miss_timing: got lat=%0d memreq=%0d, expected lat=3 memreq=2", lat, rc);
        end
    endtask

    task automatic test_timeout();
        int lat, rc;
        resp_q.push_back('{32'h0, 1'b1});
        run_txn(1'b0, 32'h300, '0, 1'b0, 32'h11112222, 0, '0, lat, rc);
        checks++;
        if (lat != TC + 1 || rc != TC) begin
            failures++;
            $display("FAIL read_timeout_timing: got lat=%0d memreq=%0d, expected lat=%0d memreq=%0d", lat, rc, TC + 1, TC);
        end
        resp_q.push_back('{32'h0, 1'b1});
        run_txn(1'b1, 32'h304, 32'h99990000, 1'b1, '0, 0, '0, lat, rc);
        checks++;
        if (lat != TC + 1 || rc != TC) begin
            failures++;
            $display("FAIL write_timeout_timing: got lat=%0d memreq=%0d, expected lat=%0d memreq=%0d", lat, rc, TC + 1, TC);
        end
        // Ack on the last allowed cycle must win over the timeout.
        fill_q.push_back('{32'h308, 32'h5EED5EED});
        resp_q.push_back('{32'h5EED5EED, 1'b0});
        run_txn(1'b0, 32'h308, '0, 1'b0, '0, TC, 32'h5EED5EED, lat, rc);
        checks++;
        if (lat != TC + 2 || rc != TC) begin
            failures++;
            $display("FAIL ack_at_timeout_timing: got lat=%0d memreq=%0d, expected lat=%0d memreq=%0d", lat, rc, TC + 2, TC);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rc;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; c_hit = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup: got mem_req=%b, expected 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, c_fill_we, cpu_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_drop: got req/fill/ready=%b, expected 000", {mem_req, c_fill_we, cpu_ready});
        end
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, c_fill_we, cpu_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_idle: got req/fill/ready=%b, expected 000", {mem_req, c_fill_we, cpu_ready});
        end
        fill_q.push_back('{32'h204, 32'h0F0F0F0F});
        resp_q.push_back('{32'h0F0F0F0F, 1'b0});
        run_txn(1'b0, 32'h204, '0, 1'b0, '0, 2, 32'h0F0F0F0F, lat, rc);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL reset_mid_next_timing: got lat=%0d, expected 4", lat);
        end
    endtask

    task automatic test_back_to_back();
        int n, cyc, cyc1, cyc2;
        n = 0; cyc = 0; cyc1 = 0; cyc2 = 0;
        resp_q.push_back('{32'h11111111, 1'b0});
        resp_q.push_back('{32'h22222222, 1'b0});
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; c_hit = 1'b1; c_rdata = 32'h11111111;
        while (n < 2 && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cpu_ready) begin
                n++;
                if (n == 1) begin
                    cyc1 = cyc;
                    cpu_addr = 32'h14;
                    c_rdata = 32'h22222222;
                end else begin
                    cyc2 = cyc;
                end
            end
        end
        cpu_req = 1'b0; c_hit = 1'b0; c_rdata = '0;
        checks++;
        if (n != 2 || cyc2 - cyc1 != 2) begin
            failures++;
            $display("FAIL back_to_back: got readies=%0d spacing=%0d, expected readies=2 spacing=2", n, cyc2 - cyc1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_stray_ack();
        int lat, rc;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, c_fill_we, cpu_ready} !== 3'b000) begin
            failures++;
            $display("FAIL stray_ack: got req/fill/ready=%b, expected 000", {mem_req, c_fill_we, cpu_ready});
        end
        resp_q.push_back('{32'h600DCAFE, 1'b0});
        run_txn(1'b0, 32'h48, '0, 1'b1, 32'h600DCAFE, 0, '0, lat, rc);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL stray_ack_next_timing: got lat=%0d, expected 1", lat);
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        int lat, rc;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
            failures++;
            $display("FAIL stats_reset: got hits=%0d misses=%0d, expected 0 0", stat_hits, stat_misses);
        end
        for (int i = 0; i < 3; i++) begin
            resp_q.push_back('{32'hAB000000 + i, 1'b0});
            run_txn(1'b0, 32'h500 + 4 * i, '0, 1'b1, 32'hAB000000 + i, 0, '0, lat, rc);
        end
        for (int i = 0; i < 2; i++) begin
            fill_q.push_back('{32'h600 + 4 * i, 32'hCD000000 + i});
            resp_q.push_back('{32'hCD000000 + i, 1'b0});
            run_txn(1'b0, 32'h600 + 4 * i, '0, 1'b0, '0, 1, 32'hCD000000 + i, lat, rc);
        end
        resp_q.push_back('{32'h0, 1'b0});
        run_txn(1'b1, 32'h700, 32'h12121212, 1'b0, '0, 1, '0, lat, rc);
        checks++;
        if (stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
            failures++;
            $display("FAIL stats_count: got hits=%0d misses=%0d, expected 3 2", stat_hits, stat_misses);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_stray_ack();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
